// File: rtl/sseg_pkg.sv
// Shared types and helpers for the seven-segment BCD front end.
// Double-dabble sizing and decimal range limits live here.
package sseg_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sseg_state_t;

  // Largest value that fits in n decimal digits.
  function automatic logic [63:0] max_dec(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r - 64'd1;
  endfunction

  // ceil(w * log10(2)): BCD digits needed for a w-bit value.
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/sseg_multi_digit_ctrl_if.sv
// Request/result bundle between a host and the seven-segment front end.
// Host drives value and controls; the front end returns BCD and enables.
interface sseg_multi_digit_ctrl_if
  import sseg_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int NUM_DIGITS = 4
);

  logic [IN_WIDTH-1:0]         value_in;
  logic                        load;
  logic                        blink_en;
  logic                        lamp_test_in;
  logic                        busy;
  logic                        done;
  logic                        overflow;
  logic [BCD_W*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]       digit_en;
  logic                        LampTest;

  modport master (
    output value_in, load, blink_en, lamp_test_in,
    input  busy, done, overflow, digits, digit_en, LampTest
  );

  modport slave (
    input  value_in, load, blink_en, lamp_test_in,
    output busy, done, overflow, digits, digit_en, LampTest
  );

endinterface

// File: rtl/sseg_blink_timer.sv
// Free-running blink divider for the display.
// phase_o is 1 in the visible half-period, toggling every BLINK_DIV cycles.
module sseg_blink_timer #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic resetN,
  output logic phase_o
);

  localparam int W = $clog2(BLINK_DIV);

  logic [W-1:0] cnt_q;
  logic         phase_q;

  // Count to BLINK_DIV-1, wrap and flip the phase.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (cnt_q == W'(BLINK_DIV - 1)) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/sseg_multi_digit_ctrl.sv
// Binary to BCD seven-segment front end with an iterative double dabble,
// leading-zero blanking, overflow saturation, blinking and lamp test.
module sseg_multi_digit_ctrl
  import sseg_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int BLANK_ZERO = 1
) (
  input  logic clk,
  input  logic resetN,
  sseg_multi_digit_ctrl_if.slave bus
);

  localparam int SCR_DIG = bcd_digits(IN_WIDTH);
  localparam int SCR_W   = BCD_W * SCR_DIG;
  localparam int OUT_W   = BCD_W * NUM_DIGITS;
  localparam int EXT_W   = (SCR_W > OUT_W) ? SCR_W : OUT_W;
  localparam int CNT_W   = $clog2(IN_WIDTH + 1);

  localparam logic [63:0]      MAX_V = max_dec(NUM_DIGITS);
  localparam logic [OUT_W-1:0] ALL9  = {NUM_DIGITS{4'h9}};

  sseg_state_t           state_q;
  logic [IN_WIDTH-1:0]   sh_q;
  logic [IN_WIDTH-1:0]   sh_d;
  logic [SCR_W-1:0]      scr_q;
  logic [SCR_W-1:0]      scr_d;
  logic [SCR_W-1:0]      adj;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ovf_pend_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ovf_q;
  logic [OUT_W-1:0]      digits_q;
  logic [NUM_DIGITS-1:0] mask_q;
  logic [NUM_DIGITS-1:0] mask_d;
  logic [OUT_W-1:0]      res;
  logic                  any_nz;
  logic                  ovf_now;
  logic                  lamp_q;
  logic                  phase;

  // Add 3 to every scratch nibble that would overflow when doubled.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < SCR_DIG; i++) begin
      if (scr_q[i*BCD_W +: BCD_W] >= 4'd5)
        adj[i*BCD_W +: BCD_W] = scr_q[i*BCD_W +: BCD_W] + 4'd3;
    end
  end

  // The bit leaving the top of the scratch is always zero by sizing.
  assign scr_d = SCR_W'({adj, sh_q[IN_WIDTH-1]});
  assign sh_d  = {sh_q[IN_WIDTH-2:0], 1'b0};
  assign res   = OUT_W'(EXT_W'(scr_d));

  assign ovf_now = 64'(bus.value_in) > MAX_V;

  // Light a digit when it or any higher digit is non-zero.
  always_comb begin
    any_nz = 1'b0;
    mask_d = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      any_nz    = any_nz | (res[i*BCD_W +: BCD_W] != 4'd0);
      mask_d[i] = any_nz;
    end
    if (BLANK_ZERO == 0) mask_d[0] = 1'b1;
  end

  // Conversion sequencer with registered status and result.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      digits_q   <= '0;
      mask_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.load) begin
            sh_q       <= bus.value_in;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= ovf_now;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          sh_q  <= sh_d;
          scr_q <= scr_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            ovf_q    <= ovf_pend_q;
            digits_q <= ovf_pend_q ? ALL9 : res;
            mask_q   <= ovf_pend_q ? '1 : mask_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Lamp test is a plain one-cycle delay.
  always_ff @(posedge clk) begin
    if (!resetN) lamp_q <= 1'b0;
    else         lamp_q <= bus.lamp_test_in;
  end

  sseg_blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk     (clk),
    .resetN  (resetN),
    .phase_o (phase)
  );

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.digits   = digits_q;
  assign bus.LampTest = lamp_q;
  assign bus.digit_en =
    mask_q & {NUM_DIGITS{~bus.blink_en | phase}};

endmodule

// File: tb/tb_sseg_multi_digit_ctrl.sv
// Randomised bench for the seven-segment front end.
// Two instances differ only in zero blanking; both see the same stimulus.
module tb_sseg_multi_digit_ctrl;

  localparam int IW = 16;
  localparam int ND = 4;
  localparam int BD = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int unsigned ncyc = 0;
  bit be_cur = 1'b0;
  int cur_v = 0;

  sseg_multi_digit_ctrl_if #(.IN_WIDTH(IW), .NUM_DIGITS(ND)) bus_a ();
  sseg_multi_digit_ctrl_if #(.IN_WIDTH(IW), .NUM_DIGITS(ND)) bus_b ();

  sseg_multi_digit_ctrl #(
    .IN_WIDTH(IW), .NUM_DIGITS(ND), .BLINK_DIV(BD), .BLANK_ZERO(1)
  ) u_dut (
    .clk(clk), .resetN(resetN), .bus(bus_a)
  );

  sseg_multi_digit_ctrl #(
    .IN_WIDTH(IW), .NUM_DIGITS(ND), .BLINK_DIV(BD), .BLANK_ZERO(0)
  ) u_dut_nz (
    .clk(clk), .resetN(resetN), .bus(bus_b)
  );

  always #5 clk = ~clk;

  // Edges since reset release, for the blink-phase model.
  always @(posedge clk) ncyc <= resetN ? ncyc + 1 : 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_digits(input int v);
    logic [15:0] r;
    int p;
    if (v > 9999) return 16'h9999;
    r = '0;
    p = 1;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_mask(input int v, input bit bz);
    logic [3:0] m;
    int p;
    if (v > 9999) return 4'hF;
    m = '0;
    p = 10;
    for (int i = 1; i < ND; i++) begin
      m[i] = (v / p) != 0;
      p = p * 10;
    end
    m[0] = (v != 0) || !bz;
    return m;
  endfunction

  function automatic bit vis();
    return ((ncyc / BD) % 2) == 0;
  endfunction

  task automatic drive(input logic [15:0] v, input bit ld, input bit lt);
    bus_a.value_in = v;     bus_b.value_in = v;
    bus_a.load = ld;        bus_b.load = ld;
    bus_a.blink_en = be_cur; bus_b.blink_en = be_cur;
    bus_a.lamp_test_in = lt; bus_b.lamp_test_in = lt;
  endtask

  // One clock with random lamp test; checks the one-cycle lamp delay.
  task automatic tick(input logic [15:0] v, input bit ld);
    bit lt;
    lt = 1'($urandom_range(0, 1));
    drive(v, ld, lt);
    @(negedge clk);
    chk("lamp", bus_a.LampTest, lt);
  endtask

  task automatic show_chk(input int v);
    logic [3:0] on;
    on = {4{~be_cur | vis()}};
    chk("digits", bus_a.digits, exp_digits(v));
    chk("ovf", bus_a.overflow, v > 9999);
    chk("en_bz1", bus_a.digit_en, exp_mask(v, 1'b1) & on);
    chk("en_bz0", bus_b.digit_en, exp_mask(v, 1'b0) & on);
  endtask

  // Load v; optionally pulse a second load k edges after the accepted one.
  task automatic convert(input int v, input int inj_at, input int inj_v);
    int done_k;
    int done_n;
    done_k = -1;
    done_n = 0;
    tick(16'(v), 1'b1);
    chk("busy_start", bus_a.busy, 1);
    chk("done_early", bus_a.done, 0);
    for (int k = 1; k <= IW + 1; k++) begin
      if (k == inj_at) tick(16'(inj_v), 1'b1);
      else             tick(16'(v), 1'b0);
      if (bus_a.done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (k == IW) begin
        chk("busy_done", bus_a.busy, 0);
        show_chk(v);
      end
    end
    chk("latency", 64'(done_k), 64'(IW));
    chk("done_cnt", 64'(done_n), 64'd1);
    chk("idle_busy", bus_a.busy, 0);
    cur_v = v;
  endtask

  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) begin
      tick(16'(cur_v), 1'b0);
      show_chk(cur_v);
    end
  endtask

  initial begin
    int v;
    int sel;
    int inj;
    int dn;
    drive(16'd0, 1'b0, 1'b0);
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_ovf", bus_a.overflow, 0);
    chk("rst_digits", bus_a.digits, 0);
    chk("rst_en_bz1", bus_a.digit_en, 0);
    chk("rst_en_bz0", bus_b.digit_en, 0);
    chk("rst_lamp", bus_a.LampTest, 0);
    resetN = 1'b1;

    be_cur = 1'b0;
    convert(1234, -1, 0);
    convert(7, -1, 0);
    convert(0, -1, 0);
    convert(12345, -1, 0);
    convert(42, -1, 0);
    convert(9999, -1, 0);
    convert(10000, -1, 0);
    convert(500, 5, 999);
    convert(300, IW + 1, 77);
    idle_run(3);

    be_cur = 1'b1;
    convert(88, -1, 0);
    idle_run(20);
    be_cur = 1'b0;
    idle_run(3);

    // Reset in the middle of a conversion.
    tick(16'd500, 1'b1);
    repeat (4) tick(16'd500, 1'b0);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    chk("mid_busy", bus_a.busy, 0);
    chk("mid_done", bus_a.done, 0);
    chk("mid_ovf", bus_a.overflow, 0);
    chk("mid_digits", bus_a.digits, 0);
    chk("mid_en", bus_a.digit_en, 0);
    chk("mid_lamp", bus_a.LampTest, 0);
    dn = 0;
    for (int i = 0; i < IW + 2; i++) begin
      tick(16'd0, 1'b0);
      if (bus_a.done) dn++;
    end
    chk("mid_nodone", 64'(dn), 0);
    convert(4321, -1, 0);

    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: v = $urandom_range(0, 9999);
        1: v = $urandom_range(0, 65535);
        2: v = $urandom_range(0, 99);
        default: begin
          case ($urandom_range(0, 3))
            0: v = 0;
            1: v = 9999;
            2: v = 10000;
            default: v = 65535;
          endcase
        end
      endcase
      be_cur = 1'($urandom_range(0, 1));
      inj = ($urandom_range(0, 2) == 0) ? $urandom_range(1, IW + 1) : -1;
      convert(v, inj, $urandom_range(0, 65535));
      idle_run($urandom_range(0, 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
